tx_rr_scheduler: RTL and testbench

// - Round-robin scheduler feeding one upstream beat stream to N_CH transmit channels (tx0..txN-1).
// - Grants one enabled channel at a time for a burst of BURST_LEN beats, then rotates to the next enabled channel.
// - Sits between the sample source and the per-channel TX lanes.
// - Replaces the free-running modulo steering with grant steering that honours enable and ready.

---
 rtl/tx_sched_pkg.sv | 41 ++++
 rtl/tx_sched_rr_pick.sv | 28 ++
 rtl/tx_rr_scheduler.sv | 146 ++++++++++++++
 tb/tb_tx_rr_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// ============================================================================
// Module   : tx_sched_pkg
// Summary  : Shared types and round-robin search helper for tx_rr_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_sched_pkg;

    localparam int unsigned c_N_CH_DEFAULT = 4;
    localparam int unsigned c_MAX_CH       = 16;
    localparam int unsigned c_MAX_ID_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Returns {found, index} of the first set mask bit strictly after 'last',
    // wrapping modulo n_ch; 'last' itself is considered only after a full lap.
    function automatic logic [c_MAX_ID_W:0] next_enabled(
        input logic [c_MAX_CH-1:0]   mask,
        input logic [c_MAX_ID_W-1:0] last,
        input int unsigned           n_ch
    );
        logic [c_MAX_ID_W:0] result;
        int unsigned         idx;
        result = '0;
        for (int unsigned i = 1; i <= c_MAX_CH; i++) begin
            idx = (32'(last) + i) % n_ch;
            if ((i <= n_ch) && !result[c_MAX_ID_W] && mask[idx[c_MAX_ID_W-1:0]]) begin
                result = {1'b1, idx[c_MAX_ID_W-1:0]};
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_sched_rr_pick.sv
// ============================================================================
// Module   : tx_sched_rr_pick
// Summary  : Combinational rotate-and-priority-encode channel picker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_sched_rr_pick
    import tx_sched_pkg::*;
#(
    parameter int unsigned N_CH = c_N_CH_DEFAULT,
    parameter int unsigned ID_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] ch_enable,
    input  logic [ID_W-1:0] last_grant,
    output logic [ID_W-1:0] pick,
    output logic            pick_valid
);

    logic [c_MAX_ID_W:0] w_result;

    assign w_result   = next_enabled(c_MAX_CH'(ch_enable), c_MAX_ID_W'(last_grant), N_CH);
    assign pick_valid = w_result[c_MAX_ID_W];
    assign pick       = ID_W'(w_result[c_MAX_ID_W-1:0]);

endmodule

`default_nettype wire

// File: rtl/tx_rr_scheduler.sv
// ============================================================================
// Module   : tx_rr_scheduler
// Summary  : Round-robin burst scheduler steering one beat stream to N_CH
//            TX lanes. Optional per-channel beat counters when
//            TX_RR_SCHEDULER_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_rr_scheduler
    import tx_sched_pkg::*;
#(
    parameter int unsigned N_CH      = c_N_CH_DEFAULT,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_LEN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         ch_enable,
    input  logic                    s_valid,
    input  logic [DATA_W-1:0]       s_data,
    output logic                    s_ready,
    output logic [N_CH-1:0]         tx_valid,
    output logic [DATA_W-1:0]       tx_data,
    input  logic [N_CH-1:0]         tx_ready,
    output logic [$clog2(N_CH)-1:0] grant_id,
    output logic                    busy
`ifdef TX_RR_SCHEDULER_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [31:0]             beat_count [N_CH]
`endif
);

    localparam int unsigned            c_ID_W      = $clog2(N_CH);
    localparam int unsigned            c_CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [c_CNT_W-1:0]     c_BURST_CNT = c_CNT_W'(BURST_LEN);

    sched_state_t        r_state;
    logic [c_CNT_W-1:0]  r_beat_cnt;
    logic [c_ID_W-1:0]   r_last_grant;
    logic [c_ID_W-1:0]   r_grant_id;
    logic [N_CH-1:0]     r_tx_valid;
    logic [DATA_W-1:0]   r_tx_data;

    logic                w_out_full;
    logic                w_tx_fire;
    logic                w_s_ready;
    logic                w_s_fire;
    logic [c_ID_W-1:0]   w_pick;
    logic                w_pick_valid;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic [N_CH-1:0]     w_grant_onehot;

    tx_sched_rr_pick #(
        .N_CH (N_CH),
        .ID_W (c_ID_W)
    ) u_pick (
        .ch_enable  (ch_enable),
        .last_grant (r_last_grant),
        .pick       (w_pick),
        .pick_valid (w_pick_valid)
    );

    assign w_out_full     = |r_tx_valid;
    assign w_tx_fire      = w_out_full && tx_ready[r_grant_id];
    // Accepting while the register drains keeps one beat per cycle flowing.
    assign w_s_ready      = (r_state == XFER) && (!w_out_full || tx_ready[r_grant_id]);
    assign w_s_fire       = s_valid && w_s_ready;
    assign w_cnt_next     = r_beat_cnt + c_CNT_W'(1);
    assign w_grant_onehot = N_CH'(1) << r_grant_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_valid <= '0;
            r_tx_data  <= '0;
        end else if (w_s_fire) begin
            r_tx_valid <= w_grant_onehot;
            r_tx_data  <= s_data;
        end else if (w_tx_fire) begin
            r_tx_valid <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_beat_cnt   <= '0;
            r_last_grant <= c_ID_W'(N_CH - 1);
            r_grant_id   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant_id <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (w_s_fire) begin
                        r_beat_cnt <= w_cnt_next;
                        if (w_cnt_next == c_BURST_CNT) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Rotate only once the last beat has left the lane.
                    if (!w_out_full || w_tx_fire) begin
                        r_last_grant <= r_grant_id;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready  = w_s_ready;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;
    assign busy     = (r_state != IDLE);

`ifdef TX_RR_SCHEDULER_STATS_EN
    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_stats
            logic [31:0] r_count;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (stats_clr) begin
                    r_count <= '0;
                end else if (r_tx_valid[g] && tx_ready[g]) begin
                    r_count <= r_count + 32'd1;
                end
            end
            assign beat_count[g] = r_count;
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_rr_scheduler.sv
// ============================================================================
// Module   : tb_tx_rr_scheduler
// Summary  : Directed self-checking bench for tx_rr_scheduler (N_CH=4,
//            BURST_LEN=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_rr_scheduler;

    localparam int unsigned c_N_CH      = 4;
    localparam int unsigned c_DATA_W    = 16;
    localparam int unsigned c_BURST_LEN = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [c_N_CH-1:0]   ch_enable = 4'hF;
    logic                s_valid = 1'b1;
    logic [c_DATA_W-1:0] s_data = 16'h0010;
    logic                s_ready;
    logic [c_N_CH-1:0]   tx_valid;
    logic [c_DATA_W-1:0] tx_data;
    logic [c_N_CH-1:0]   tx_ready = 4'hF;
    logic [1:0]          grant_id;
    logic                busy;
`ifdef TX_RR_SCHEDULER_STATS_EN
    logic                stats_clr = 1'b0;
    logic [31:0]         beat_count [c_N_CH];
`endif

    int           n_checks = 0;
    int           n_pass   = 0;
    int           cyc      = 0;
    logic [31:0]  log_q[$];
    int           log_cyc[$];
    logic [3:0]   seen_valid;

    tx_rr_scheduler #(
        .N_CH      (c_N_CH),
        .DATA_W    (c_DATA_W),
        .BURST_LEN (c_BURST_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_enable  (ch_enable),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef TX_RR_SCHEDULER_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .beat_count (beat_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ent(input int ch, input int data);
        return 32'((ch << 16) | data);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock: sample handshakes on the falling edge, advance the source
    // after an accepted beat, return #1 after the rising edge.
    task automatic cycle();
        logic s_fire;
        @(negedge clk);
        s_fire = s_valid && s_ready;
        seen_valid = seen_valid | tx_valid;
        for (int i = 0; i < 4; i++) begin
            if (tx_valid[i] && tx_ready[i]) begin
                log_q.push_back(ent(i, int'(tx_data)));
                log_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_fire) s_data = s_data + 16'd1;
    endtask

    task automatic start_test(input logic [3:0] en);
        rst_n      = 1'b0;
        ch_enable  = en;
        s_valid    = 1'b1;
        s_data     = 16'h0010;
        tx_ready   = 4'hF;
        log_q.delete();
        log_cyc.delete();
        seen_valid = 4'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    int t2_ch [8] = '{1, 1, 3, 3, 1, 1, 3, 3};
    int t5_ch [10] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data",  32'(tx_data),  32'h0);
        check("rst_s_ready",  32'(s_ready),  32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_busy",     32'(busy),     32'h0);

        // T1: all channels enabled
        start_test(4'hF);
        repeat (18) cycle();
        check("t1_count", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check("t1_beat", log_q[i], ent(i / 2, 16'h10 + i));
        check("t1_latency", 32'(log_cyc[0]), 32'd2);
        check("t1_bubble",  32'(log_cyc[2] - log_cyc[1]), 32'd3);
`ifdef TX_RR_SCHEDULER_STATS_EN
        for (int i = 0; i < 4; i++) check("t1_stats", beat_count[i], 32'd2);
`endif

        // T2: sparse mask 1010
        start_test(4'b1010);
        repeat (18) cycle();
        check("t2_count", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check("t2_beat", log_q[i], ent(t2_ch[i], 16'h10 + i));
        check("t2_seen_valid", 32'(seen_valid), 32'b1010);

        // T3: channel 0 stalls after its first beat
        start_test(4'hF);
        cycle();
        cycle();
        tx_ready = 4'hE;
        #1;
        check("t3_hold_valid", 32'(tx_valid), 32'h1);
        check("t3_hold_data",  32'(tx_data),  32'h10);
        check("t3_hold_ready", 32'(s_ready),  32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_stall_valid", 32'(tx_valid), 32'h1);
            check("t3_stall_data",  32'(tx_data),  32'h10);
            check("t3_stall_ready", 32'(s_ready),  32'h0);
        end
        check("t3_no_moves", 32'(log_q.size()), 32'd0);
        tx_ready = 4'hF;
        cycle();
        check("t3_next_valid", 32'(tx_valid), 32'h1);
        check("t3_next_data",  32'(tx_data),  32'h11);
        check("t3_first_beat", log_q[0], ent(0, 16'h10));

        // T4: nothing enabled, then only channel 2
        start_test(4'h0);
        repeat (5) cycle();
        check("t4_idle_busy",  32'(busy),    32'h0);
        check("t4_idle_ready", 32'(s_ready), 32'h0);
        check("t4_idle_moves", 32'(log_q.size()), 32'd0);
        ch_enable = 4'h4;
        cycle();
        check("t4_grant", 32'(grant_id), 32'd2);
        check("t4_busy",  32'(busy),     32'h1);
        cycle();
        cycle();
        check("t4_count", 32'(log_q.size()), 32'd1);
        check("t4_beat",  log_q[0], ent(2, 16'h10));

        // T5: mask shrinks to ch0 during ch1's first beat
        start_test(4'hF);
        repeat (6) cycle();
        check("t5_ch1_first", 32'(tx_valid), 32'b0010);
        ch_enable = 4'h1;
        repeat (14) cycle();
        check("t5_count", 32'(log_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) check("t5_beat", log_q[i], ent(t5_ch[i], 16'h10 + i));

        // T6: asynchronous reset while ch2 holds a beat
        start_test(4'hF);
        repeat (10) cycle();
        check("t6_pre_valid", 32'(tx_valid), 32'b0100);
        check("t6_pre_grant", 32'(grant_id), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("t6_rst_tx_data",  32'(tx_data),  32'h0);
        check("t6_rst_s_ready",  32'(s_ready),  32'h0);
        check("t6_rst_grant_id", 32'(grant_id), 32'h0);
        check("t6_rst_busy",     32'(busy),     32'h0);
`ifdef TX_RR_SCHEDULER_STATS_EN
        for (int i = 0; i < 4; i++) check("t6_rst_stats", beat_count[i], 32'd0);
`endif
        @(posedge clk);
        #1;
        s_data = 16'h0020;
        log_q.delete();
        log_cyc.delete();
        rst_n = 1'b1;
        cyc   = 0;
        cycle();
        check("t6_grant", 32'(grant_id), 32'd0);
        check("t6_busy",  32'(busy),     32'h1);
        cycle();
        cycle();
        check("t6_beat", log_q[0], ent(0, 16'h20));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
